mips_mc_control: RTL and testbench



---
 rtl/mips_mc_control.sv | 256 +++++++++++++++++++++++++
 tb/tb_mips_mc_control.sv | 268 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/mips_mc_control.sv
// mips_mc_control: multi-cycle FETCH/DECODE/EXEC/MEM/WB sequencer owning PC and IR.
// Optional: define MIPS_MC_BNE_EN to decode bne (000101); otherwise that opcode is illegal.
module mips_mc_control #(
  parameter int              DW       = 32,
  parameter int              AW       = 32,
  parameter logic [AW-1:0]   PC_RESET = '0
) (
  input  logic          clock,
  input  logic          reset,
  output logic          imem_req,
  output logic [AW-1:0] imem_addr,
  input  logic [DW-1:0] imem_rdata,
  input  logic          imem_ready,
  output logic          dmem_req,
  output logic          dmem_we,
  input  logic          dmem_ready,
  input  logic          alu_zero,
  input  logic [AW-1:0] rs_data,
  output logic [DW-1:0] instr,
  output logic [AW-1:0] pc,
  output logic          reg_write,
  output logic [1:0]    reg_dst,
  output logic          mem_to_reg,
  output logic          alu_src,
  output logic [2:0]    ula_operation,
  output logic          is_jal,
  output logic          retire,
  output logic          illegal
);

`ifdef MIPS_MC_BNE_EN
  localparam logic BNE_EN = 1'b1;
`else
  localparam logic BNE_EN = 1'b0;
`endif

  typedef enum logic [2:0] {
    S_IDLE, S_FETCH, S_DECODE, S_EXEC, S_MEM, S_WB
  } state_t;

  typedef enum logic [3:0] {
    C_R, C_JR, C_J, C_JAL, C_ADDI, C_LW, C_SW, C_BEQ, C_BNE, C_ILL
  } cls_t;

  typedef struct packed {
    logic       imem_req;
    logic       dmem_req;
    logic       dmem_we;
    logic       reg_write;
    logic [1:0] reg_dst;
    logic       mem_to_reg;
    logic       alu_src;
    logic [2:0] ula_op;
    logic       is_jal;
    logic       retire;
    logic       illegal;
  } ctrl_t;

  function automatic cls_t decode_cls(input logic [DW-1:0] ir);
    cls_t c;
    case (ir[31:26])
      6'b000000: c = (ir[5:0] == 6'b001000) ? C_JR : C_R;
      6'b000010: c = C_J;
      6'b000011: c = C_JAL;
      6'b001000: c = C_ADDI;
      6'b100011: c = C_LW;
      6'b101011: c = C_SW;
      6'b000100: c = C_BEQ;
      6'b000101: c = BNE_EN ? C_BNE : C_ILL;
      default:   c = C_ILL;
    endcase
    return c;
  endfunction

  function automatic logic [2:0] ula_op_of(input cls_t c);
    logic [2:0] op;
    case (c)
      C_R:          op = 3'b010;
      C_BEQ, C_BNE: op = 3'b001;
      default:      op = 3'b000;
    endcase
    return op;
  endfunction

  function automatic logic alu_src_of(input cls_t c);
    return (c == C_ADDI) || (c == C_LW) || (c == C_SW);
  endfunction

  // Output strobes for a given state: registered so every output is a clean Moore decode.
  function automatic ctrl_t ctrl_for(input state_t st, input cls_t c);
    ctrl_t o;
    o = '0;
    case (st)
      S_FETCH: o.imem_req = 1'b1;
      S_DECODE: begin
        o.retire  = (c == C_J) || (c == C_JR) || (c == C_ILL);
        o.illegal = (c == C_ILL);
      end
      S_EXEC: begin
        o.alu_src = alu_src_of(c);
        o.ula_op  = ula_op_of(c);
        o.retire  = (c == C_BEQ) || (c == C_BNE);
      end
      S_MEM: begin
        o.dmem_req = 1'b1;
        o.dmem_we  = (c == C_SW);
        o.alu_src  = alu_src_of(c);
        o.ula_op   = ula_op_of(c);
      end
      S_WB: begin
        o.reg_write  = 1'b1;
        o.reg_dst    = (c == C_R) ? 2'b01 : ((c == C_JAL) ? 2'b10 : 2'b00);
        o.mem_to_reg = (c == C_LW);
        o.is_jal     = (c == C_JAL);
        o.alu_src    = alu_src_of(c);
        o.ula_op     = ula_op_of(c);
        o.retire     = 1'b1;
      end
      default: o = '0;
    endcase
    return o;
  endfunction

  state_t        r_state;
  logic [AW-1:0] r_pc;
  logic [DW-1:0] r_instr;
  ctrl_t         r_ctrl;

  cls_t          w_cls;
  cls_t          w_in_cls;
  logic [AW-1:0] w_pc_inc;
  logic [AW-1:0] w_br_off;
  logic [AW-1:0] w_jtgt;
  logic          w_taken;

  // Next-PC candidates and instruction class of the held and the incoming word.
  always_comb begin
    w_cls       = decode_cls(r_instr);
    w_in_cls    = decode_cls(imem_rdata);
    w_pc_inc    = r_pc + AW'(32'd4);
    w_br_off    = {{(AW-18){r_instr[15]}}, r_instr[15:0], 2'b00};
    w_jtgt      = r_pc;
    w_jtgt[27:0] = {r_instr[25:0], 2'b00};
    w_taken     = ((w_cls == C_BEQ) && alu_zero) || ((w_cls == C_BNE) && !alu_zero);
  end

  // Sequencer: state, PC, IR and the registered control strobes of the next state.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_state <= S_IDLE;
      r_pc    <= PC_RESET;
      r_instr <= '0;
      r_ctrl  <= '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          r_state <= S_FETCH;
          r_ctrl  <= ctrl_for(S_FETCH, w_cls);
        end
        S_FETCH: begin
          if (imem_ready) begin
            r_instr <= imem_rdata;
            r_pc    <= w_pc_inc;
            r_state <= S_DECODE;
            r_ctrl  <= ctrl_for(S_DECODE, w_in_cls);
          end
        end
        S_DECODE: begin
          case (w_cls)
            C_J: begin
              r_pc    <= w_jtgt;
              r_state <= S_FETCH;
              r_ctrl  <= ctrl_for(S_FETCH, w_cls);
            end
            C_JR: begin
              r_pc    <= rs_data;
              r_state <= S_FETCH;
              r_ctrl  <= ctrl_for(S_FETCH, w_cls);
            end
            C_ILL: begin
              r_state <= S_FETCH;
              r_ctrl  <= ctrl_for(S_FETCH, w_cls);
            end
            C_JAL: begin
              r_state <= S_WB;
              r_ctrl  <= ctrl_for(S_WB, w_cls);
            end
            default: begin
              r_state <= S_EXEC;
              r_ctrl  <= ctrl_for(S_EXEC, w_cls);
            end
          endcase
        end
        S_EXEC: begin
          if (w_taken) begin
            r_pc <= r_pc + w_br_off;
          end
          case (w_cls)
            C_R, C_ADDI: begin
              r_state <= S_WB;
              r_ctrl  <= ctrl_for(S_WB, w_cls);
            end
            C_LW, C_SW: begin
              r_state <= S_MEM;
              r_ctrl  <= ctrl_for(S_MEM, w_cls);
            end
            default: begin
              r_state <= S_FETCH;
              r_ctrl  <= ctrl_for(S_FETCH, w_cls);
            end
          endcase
        end
        S_MEM: begin
          if (dmem_ready) begin
            if (w_cls == C_SW) begin
              r_state <= S_FETCH;
              r_ctrl  <= ctrl_for(S_FETCH, w_cls);
            end else begin
              r_state <= S_WB;
              r_ctrl  <= ctrl_for(S_WB, w_cls);
            end
          end
        end
        S_WB: begin
          // jal keeps pc+4 visible during WB for the link write, then jumps.
          if (w_cls == C_JAL) begin
            r_pc <= w_jtgt;
          end
          r_state <= S_FETCH;
          r_ctrl  <= ctrl_for(S_FETCH, w_cls);
        end
        default: begin
          r_state <= S_IDLE;
          r_ctrl  <= '0;
        end
      endcase
    end
  end

  assign imem_req      = r_ctrl.imem_req;
  assign imem_addr     = r_pc;
  assign dmem_req      = r_ctrl.dmem_req;
  assign dmem_we       = r_ctrl.dmem_we;
  assign instr         = r_instr;
  assign pc            = r_pc;
  assign reg_write     = r_ctrl.reg_write;
  assign reg_dst       = r_ctrl.reg_dst;
  assign mem_to_reg    = r_ctrl.mem_to_reg;
  assign alu_src       = r_ctrl.alu_src;
  assign ula_operation = r_ctrl.ula_op;
  assign is_jal        = r_ctrl.is_jal;
  assign illegal       = r_ctrl.illegal;
  // A store completes in the very cycle dmem_ready arrives, so its retire follows the handshake.
  assign retire        = r_ctrl.retire | ((r_state == S_MEM) && (w_cls == C_SW) && dmem_ready);

endmodule

// File: tb/tb_mips_mc_control.sv
// tb_mips_mc_control: scoreboard bench; expected per-instruction results are queued and popped on retire.
module tb_mips_mc_control;
  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic [31:0] imem_rdata = 32'd0;
  logic        imem_ready = 1'b0;
  logic        dmem_req;
  logic        dmem_we;
  logic        dmem_ready = 1'b0;
  logic        alu_zero = 1'b0;
  logic [31:0] rs_data = 32'd0;
  logic [31:0] instr;
  logic [31:0] pc;
  logic        reg_write;
  logic [1:0]  reg_dst;
  logic        mem_to_reg;
  logic        alu_src;
  logic [2:0]  ula_operation;
  logic        is_jal;
  logic        retire;
  logic        illegal;

  mips_mc_control #(.DW(32), .AW(32), .PC_RESET(32'd0)) dut (
    .clock(clock), .reset(reset),
    .imem_req(imem_req), .imem_addr(imem_addr), .imem_rdata(imem_rdata), .imem_ready(imem_ready),
    .dmem_req(dmem_req), .dmem_we(dmem_we), .dmem_ready(dmem_ready),
    .alu_zero(alu_zero), .rs_data(rs_data), .instr(instr), .pc(pc),
    .reg_write(reg_write), .reg_dst(reg_dst), .mem_to_reg(mem_to_reg), .alu_src(alu_src),
    .ula_operation(ula_operation), .is_jal(is_jal), .retire(retire), .illegal(illegal)
  );

  always #5 clock = ~clock;

  typedef struct {
    int          cyc;
    logic        wr;
    logic [1:0]  dst;
    logic        m2r;
    logic        jal;
    logic        asrc;
    logic        ill;
    int          dreq;
    logic        we;
    logic [31:0] pc_wb;
    logic [31:0] pc_nxt;
  } exp_t;

  exp_t        sb_q[$];
  int          n_vec = 0;
  int          n_err = 0;
  int          imem_wait = 0;
  int          dmem_wait = 0;
  logic        mon_pend = 1'b0;
  logic [31:0] imem_m [logic [31:0]];

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic push_exp(input int cyc, input logic wr, input logic [1:0] dst, input logic m2r,
                          input logic jal, input logic asrc, input logic ill, input int dreq,
                          input logic we, input logic [31:0] pc_wb, input logic [31:0] pc_nxt);
    exp_t e;
    e.cyc = cyc; e.wr = wr; e.dst = dst; e.m2r = m2r; e.jal = jal; e.asrc = asrc;
    e.ill = ill; e.dreq = dreq; e.we = we; e.pc_wb = pc_wb; e.pc_nxt = pc_nxt;
    sb_q.push_back(e);
  endtask

  // Memory responders with programmable wait states; unmapped fetch addresses stall.
  initial begin : mem_model
    int icnt;
    int dcnt;
    icnt = 0;
    dcnt = 0;
    forever begin
      @(negedge clock);
      if (imem_req && !reset) begin
        icnt = icnt + 1;
        if (imem_m.exists(imem_addr) && icnt > imem_wait) begin
          imem_ready = 1'b1;
          imem_rdata = imem_m[imem_addr];
        end else begin
          imem_ready = 1'b0;
          imem_rdata = 32'hDEAD_BEEF;
        end
      end else begin
        icnt = 0;
        imem_ready = 1'b0;
      end
      if (dmem_req && !reset) begin
        dcnt = dcnt + 1;
        dmem_ready = (dcnt > dmem_wait);
      end else begin
        dcnt = 0;
        dmem_ready = 1'b0;
      end
    end
  end

  // Monitor: accumulates per-instruction observations and compares against the queue on retire.
  initial begin : monitor
    int          cyc;
    int          o_wr;
    int          o_dreq;
    logic        prev_req;
    logic [1:0]  o_dst;
    logic        o_m2r, o_jal, o_asrc, o_ill, o_we;
    logic [31:0] o_pcwb;
    logic [31:0] pend_pc;
    exp_t        e;
    cyc = 0; o_wr = 0; o_dreq = 0; prev_req = 1'b0; pend_pc = 32'd0;
    o_dst = 2'b00; o_m2r = 1'b0; o_jal = 1'b0; o_asrc = 1'b0; o_ill = 1'b0; o_we = 1'b0;
    o_pcwb = 32'd0;
    forever begin
      @(negedge clock);
      #2;
      if (reset) begin
        prev_req = 1'b0;
        mon_pend = 1'b0;
        cyc = 0;
      end else begin
        if (mon_pend) begin
          check_val("pc_next", pc, pend_pc);
          mon_pend = 1'b0;
        end
        if (imem_req && !prev_req) begin
          cyc = 1; o_wr = 0; o_dreq = 0; o_dst = 2'b00; o_m2r = 1'b0; o_jal = 1'b0;
          o_asrc = 1'b0; o_ill = 1'b0; o_we = 1'b0; o_pcwb = 32'd0;
        end else begin
          cyc = cyc + 1;
        end
        prev_req = imem_req;
        if (reg_write) begin
          o_wr = o_wr + 1; o_dst = reg_dst; o_m2r = mem_to_reg; o_jal = is_jal;
          o_asrc = alu_src; o_pcwb = pc;
        end
        if (illegal) o_ill = 1'b1;
        if (dmem_req) begin
          o_dreq = o_dreq + 1;
          o_we = o_we | dmem_we;
        end
        if (retire) begin
          check_val("sb_nonempty", sb_q.size() != 0, 32'd1);
          if (sb_q.size() != 0) begin
            e = sb_q.pop_front();
            check_val("cycles", cyc, e.cyc);
            check_val("reg_write_cnt", o_wr, {31'd0, e.wr});
            check_val("reg_dst", o_dst, e.dst);
            check_val("mem_to_reg", o_m2r, e.m2r);
            check_val("is_jal", o_jal, e.jal);
            check_val("alu_src_wb", o_asrc, e.asrc);
            check_val("illegal", o_ill, e.ill);
            check_val("dmem_req_cycles", o_dreq, e.dreq);
            check_val("dmem_we", o_we, e.we);
            if (e.wr) check_val("pc_in_wb", o_pcwb, e.pc_wb);
            pend_pc  = e.pc_nxt;
            mon_pend = 1'b1;
          end
        end
      end
    end
  end

  task automatic reset_seq();
    reset = 1'b1;
    repeat (2) @(posedge clock);
    #1;
    check_val("rst_pc", pc, 32'd0);
    check_val("rst_instr", instr, 32'd0);
    check_val("rst_strobes", {imem_req, dmem_req, dmem_we, reg_write, mem_to_reg, alu_src,
                              is_jal, retire, illegal}, 32'd0);
    check_val("rst_reg_dst", reg_dst, 32'd0);
    check_val("rst_ula_op", ula_operation, 32'd0);
    @(posedge clock);
    #1;
    reset = 1'b0;
    @(negedge clock); #2;
    check_val("idle_no_req", imem_req, 32'd1 - 32'd1 + {31'd0, 1'b0} + 32'd0 + 32'd0);
    @(negedge clock); #2;
    check_val("fetch_req", imem_req, 32'd1);
  endtask

  task automatic wait_drain(input string tag);
    for (int i = 0; i < 400; i++) begin
      @(negedge clock); #3;
      if (sb_q.size() == 0 && !mon_pend) break;
    end
    check_val(tag, sb_q.size(), 32'd0);
  endtask

  initial begin
    // Run A: straight-line program, zero-wait fetch, 3 data wait states, branch taken.
    reset = 1'b1;
    alu_zero = 1'b1; rs_data = 32'h200; imem_wait = 0; dmem_wait = 3;
    imem_m.delete();
    imem_m[32'h000] = 32'h2008_0005;
    imem_m[32'h004] = 32'h0109_4020;
    imem_m[32'h008] = 32'h8C0A_0000;
    imem_m[32'h00C] = 32'h0800_0004;
    imem_m[32'h010] = 32'h1109_0003;
    imem_m[32'h020] = 32'hAD0A_0000;
    imem_m[32'h024] = 32'h0100_0008;
    imem_m[32'h200] = 32'h0800_0040;
    imem_m[32'h100] = 32'h0C00_0040;
    push_exp(4, 1'b1, 2'b00, 1'b0, 1'b0, 1'b1, 1'b0, 0, 1'b0, 32'h004, 32'h004);
    push_exp(4, 1'b1, 2'b01, 1'b0, 1'b0, 1'b0, 1'b0, 0, 1'b0, 32'h008, 32'h008);
    push_exp(8, 1'b1, 2'b00, 1'b1, 1'b0, 1'b1, 1'b0, 4, 1'b0, 32'h00C, 32'h00C);
    push_exp(2, 1'b0, 2'b00, 1'b0, 1'b0, 1'b0, 1'b0, 0, 1'b0, 32'h000, 32'h010);
    push_exp(3, 1'b0, 2'b00, 1'b0, 1'b0, 1'b0, 1'b0, 0, 1'b0, 32'h000, 32'h020);
    push_exp(7, 1'b0, 2'b00, 1'b0, 1'b0, 1'b0, 1'b0, 4, 1'b1, 32'h000, 32'h024);
    push_exp(2, 1'b0, 2'b00, 1'b0, 1'b0, 1'b0, 1'b0, 0, 1'b0, 32'h000, 32'h200);
    push_exp(2, 1'b0, 2'b00, 1'b0, 1'b0, 1'b0, 1'b0, 0, 1'b0, 32'h000, 32'h100);
    push_exp(3, 1'b1, 2'b10, 1'b0, 1'b1, 1'b0, 1'b0, 0, 1'b0, 32'h104, 32'h100);
    reset_seq();
    wait_drain("drain_run_a");

    // Run B: one fetch wait state, branch not taken, illegal opcode, bne.
    reset = 1'b1;
    alu_zero = 1'b0; imem_wait = 1; dmem_wait = 0;
    imem_m.delete();
    imem_m[32'h000] = 32'h0800_0004;
    imem_m[32'h010] = 32'h1109_0003;
    imem_m[32'h014] = 32'hFC00_0000;
    imem_m[32'h018] = 32'h8C0A_0000;
    imem_m[32'h01C] = 32'h1509_0003;
    push_exp(3, 1'b0, 2'b00, 1'b0, 1'b0, 1'b0, 1'b0, 0, 1'b0, 32'h000, 32'h010);
    push_exp(4, 1'b0, 2'b00, 1'b0, 1'b0, 1'b0, 1'b0, 0, 1'b0, 32'h000, 32'h014);
    push_exp(3, 1'b0, 2'b00, 1'b0, 1'b0, 1'b0, 1'b1, 0, 1'b0, 32'h000, 32'h018);
    push_exp(6, 1'b1, 2'b00, 1'b1, 1'b0, 1'b1, 1'b0, 1, 1'b0, 32'h01C, 32'h01C);
`ifdef MIPS_MC_BNE_EN
    push_exp(4, 1'b0, 2'b00, 1'b0, 1'b0, 1'b0, 1'b0, 0, 1'b0, 32'h000, 32'h02C);
`else
    push_exp(3, 1'b0, 2'b00, 1'b0, 1'b0, 1'b0, 1'b1, 0, 1'b0, 32'h000, 32'h020);
`endif
    reset_seq();
    wait_drain("drain_run_b");

    // Run C: reset asserted while a store waits in MEM.
    reset = 1'b1;
    imem_wait = 0; dmem_wait = 1000;
    imem_m.delete();
    imem_m[32'h000] = 32'hAD0A_0000;
    reset_seq();
    for (int i = 0; i < 20; i++) begin
      @(negedge clock); #3;
      if (dmem_req) break;
    end
    check_val("reach_mem", dmem_req, 32'd1);
    check_val("pc_in_mem", pc, 32'h004);
    @(posedge clock); #1;
    reset = 1'b1;
    #1;
    check_val("abort_dmem_req", dmem_req, 32'd0);
    check_val("abort_pc", pc, 32'd0);
    check_val("abort_strobes", {dmem_we, reg_write, retire, imem_req}, 32'd0);
    @(posedge clock); #1;
    check_val("held_strobes", {dmem_req, reg_write, retire, imem_req}, 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
